instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Front end of the single-cycle MIPS-31 core: fetches one instruction word from IMEM over a req/ack handshake and registers the raw word.
- Decodes the word into the 32-bit one-hot instruction vector consumed by the control unit (bits 0..30 = the 31 supported instructions, bit 31 = illegal).
- Provides handshake timeout detection and a saturating illegal-instruction counter.

Parameters:
- TIMEOUT, 16, max cycles spent in REQ without im_ack before bus error (>=2)
- CNT_W, 16, width of illegal_cnt

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  in  32  fetch address, sampled on fetch_start
- fetch_start  in  1  start one fetch; honoured only in IDLE
- im_req  out  1  IMEM read request
- im_addr  out  32  IMEM word address, stable while im_req=1
- im_ack  in  1  IMEM read data valid
- im_rdata  in  32  IMEM read data, valid when im_ack=1
- ir  out  32  registered raw instruction word
- instruct  out  32  registered one-hot decode
- dec_valid  out  1  one-cycle pulse when ir/instruct update
- busy  out  1  high in REQ
- bus_err  out  1  sticky timeout flag
- illegal_cnt  out  CNT_W  saturating count of illegal decodes

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; wait counter 0.
- FSM states: IDLE and REQ.
- IDLE, fetch_start=1 at edge N:
  - im_addr<=pc, im_req<=1, bus_err<=0, wait counter<=0, state<=REQ.
  - busy=1 from N+1.
- REQ:
  - im_req and im_addr are held.
  - The wait counter increments each cycle.
  - fetch_start is ignored.
- REQ with im_ack=1 at edge M:
  - ir<=im_rdata; instruct<=decode(im_rdata); dec_valid<=1 for exactly one cycle.
  - im_req<=0; state<=IDLE.
  - Minimum latency: fetch_start edge to dec_valid is 2 edges.
- REQ timeout: wait counter reaches TIMEOUT-1 with im_ack=0:
  - bus_err<=1; im_req<=0; instruct<=0; ir unchanged; no dec_valid; state<=IDLE.
- im_ack and timeout in the same cycle: ack wins, no bus_err.
- im_ack in IDLE: ignored, no register change.
- instruct and ir hold their values between fetches.
- Decode rules for R-type (opcode 0), by funct:
  - 0x20 -> bit0 add; 0x21 -> 1 addu; 0x22 -> 2 sub; 0x23 -> 3 subu
  - 0x24 -> 4 and; 0x25 -> 5 or; 0x26 -> 6 xor; 0x27 -> 7 nor
  - 0x2A -> 8 slt; 0x2B -> 9 sltu
  - 0x00 -> 10 sll; 0x02 -> 11 srl; 0x03 -> 12 sra
  - 0x04 -> 13 sllv; 0x06 -> 14 srlv; 0x07 -> 15 srav
  - 0x08 -> 16 jr
- Decode rules for all other opcodes:
  - 0x08 -> 17 addi; 0x09 -> 18 addiu; 0x0C -> 19 andi; 0x0D -> 20 ori; 0x0E -> 21 xori
  - 0x23 -> 22 lw; 0x2B -> 23 sw; 0x04 -> 24 beq; 0x05 -> 25 bne
  - 0x0A -> 26 slti; 0x0B -> 27 sltiu; 0x0F -> 28 lui
  - 0x02 -> 29 j; 0x03 -> 30 jal
- Decode boundary rules:
  - rs/rt/rd/shamt are not checked. 0x00000000 decodes as sll (bit10, nop).
  - Exactly one bit of instruct is set after every successful fetch.
  - Any unmatched opcode/funct: instruct=0x80000000, and illegal_cnt increments on the same edge, saturating at all-ones.

Test Plan:
- Reset, then fetch_start with pc=0x00400000; ack after 1 cycle with im_rdata=0x00221820 (add $3,$1,$2) -> im_addr=0x00400000; instruct=0x00000001; ir=0x00221820; one dec_valid pulse; busy back to 0.
- im_rdata=0x8C220004 (lw), ack delayed 5 cycles -> im_req/im_addr stable for 5 cycles; instruct=0x00400000.
- im_rdata=0x0C000010 (jal) -> instruct=0x40000000; fetch_start pulsed during REQ -> no second request.
- im_rdata=0xFC000000 twice -> instruct=0x80000000 both times; illegal_cnt=2. Preload illegal_cnt to 0xFFFF -> stays 0xFFFF.
- TIMEOUT=8, no ack -> after 8 REQ cycles: bus_err=1, im_req=0, instruct=0, no dec_valid. Next fetch_start clears bus_err. Ack on the final cycle -> normal decode, bus_err=0.
- rst_n low mid-REQ (async, between edges) -> im_req, busy, instruct, ir, illegal_cnt drop to 0 immediately. Late im_ack after release -> ignored.

Source files
------------

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_decode
//  Purpose  : Instruction front end. Fetches one word from IMEM over a
//             req/ack handshake, registers the raw word and decodes it into
//             a one-hot instruction vector (bits 0..30 = supported
//             instructions, bit 31 = illegal). Detects handshake timeouts
//             and counts illegal decodes with a saturating counter.
//  Ports    : clk, rst_n            clock / async active-low reset
//             pc, fetch_start       fetch address and start strobe (IDLE only)
//             im_req, im_addr       IMEM request and word address
//             im_ack, im_rdata      IMEM data valid and read data
//             ir, instruct          registered raw word and one-hot decode
//             dec_valid             one-cycle pulse when ir/instruct update
//             busy                  high while a request is outstanding
//             bus_err               sticky handshake-timeout flag
//             illegal_cnt           saturating count of illegal decodes
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_decode #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc,
    input  logic             fetch_start,
    output logic             im_req,
    output logic [31:0]      im_addr,
    input  logic             im_ack,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      ir,
    output logic [31:0]      instruct,
    output logic             dec_valid,
    output logic             busy,
    output logic             bus_err,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic              w_start;
    logic              w_ack;
    logic              w_timeout;
    logic [31:0]       w_decoded;

    // One-hot decode. Register fields (rs/rt/rd/shamt) are deliberately not
    // inspected, so 0x00000000 lands on sll like any other nop encoding.
    function automatic logic [31:0] decode(input logic [31:0] word);
        logic [31:0] onehot;
        onehot = 32'h8000_0000;
        case (word[31:26])
            6'h00: begin
                case (word[5:0])
                    6'h20: onehot = 32'h0000_0001;
                    6'h21: onehot = 32'h0000_0002;
                    6'h22: onehot = 32'h0000_0004;
                    6'h23: onehot = 32'h0000_0008;
                    6'h24: onehot = 32'h0000_0010;
                    6'h25: onehot = 32'h0000_0020;
                    6'h26: onehot = 32'h0000_0040;
                    6'h27: onehot = 32'h0000_0080;
                    6'h2A: onehot = 32'h0000_0100;
                    6'h2B: onehot = 32'h0000_0200;
                    6'h00: onehot = 32'h0000_0400;
                    6'h02: onehot = 32'h0000_0800;
                    6'h03: onehot = 32'h0000_1000;
                    6'h04: onehot = 32'h0000_2000;
                    6'h06: onehot = 32'h0000_4000;
                    6'h07: onehot = 32'h0000_8000;
                    6'h08: onehot = 32'h0001_0000;
                    default: onehot = 32'h8000_0000;
                endcase
            end
            6'h08: onehot = 32'h0002_0000;
            6'h09: onehot = 32'h0004_0000;
            6'h0C: onehot = 32'h0008_0000;
            6'h0D: onehot = 32'h0010_0000;
            6'h0E: onehot = 32'h0020_0000;
            6'h23: onehot = 32'h0040_0000;
            6'h2B: onehot = 32'h0080_0000;
            6'h04: onehot = 32'h0100_0000;
            6'h05: onehot = 32'h0200_0000;
            6'h0A: onehot = 32'h0400_0000;
            6'h0B: onehot = 32'h0800_0000;
            6'h0F: onehot = 32'h1000_0000;
            6'h02: onehot = 32'h2000_0000;
            6'h03: onehot = 32'h4000_0000;
            default: onehot = 32'h8000_0000;
        endcase
        return onehot;
    endfunction

    assign w_decoded = decode(im_rdata);
    assign busy      = (r_state == ST_REQ);

    // Next-state and handshake events. An ack on the last allowed wait
    // cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = fetch_start;
                if (fetch_start) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_ack     = im_ack;
                w_timeout = !im_ack && (r_wait == c_wait_last);
                if (im_ack || (r_wait == c_wait_last)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait      <= '0;
            im_req      <= 1'b0;
            im_addr     <= '0;
            ir          <= '0;
            instruct    <= '0;
            dec_valid   <= 1'b0;
            bus_err     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            dec_valid <= 1'b0;
            if (w_start) begin
                im_addr <= pc;
                im_req  <= 1'b1;
                bus_err <= 1'b0;
                r_wait  <= '0;
            end else if (w_ack) begin
                ir        <= im_rdata;
                instruct  <= w_decoded;
                dec_valid <= 1'b1;
                im_req    <= 1'b0;
                if (w_decoded[31] && !(&illegal_cnt)) begin
                    illegal_cnt <= illegal_cnt + 1'b1;
                end
            end else if (w_timeout) begin
                bus_err  <= 1'b1;
                im_req   <= 1'b0;
                instruct <= '0;
            end else if (r_state == ST_REQ) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_decode
//  Purpose  : Directed self-checking bench for instr_fetch_decode
//             (TIMEOUT=8, CNT_W=4 so counter saturation is reachable).
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        fetch_start;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] ir;
    logic [31:0] instruct;
    logic        dec_valid;
    logic        busy;
    logic        bus_err;
    logic [3:0]  illegal_cnt;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_decode #(
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .fetch_start (fetch_start),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .ir          (ir),
        .instruct    (instruct),
        .dec_valid   (dec_valid),
        .busy        (busy),
        .bus_err     (bus_err),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a fetch, hold off the ack for wait_cycles REQ cycles, then ack.
    // Returns #1 after the ack edge. poke pulses fetch_start during REQ.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d,
                            input int wait_cycles, input bit poke);
        @(posedge clk); #1;
        pc          = a;
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        chk("start_busy",   {31'd0, busy},    32'd1);
        chk("start_req",    {31'd0, im_req},  32'd1);
        chk("start_addr",   im_addr,          a);
        chk("start_buserr", {31'd0, bus_err}, 32'd0);
        for (int i = 0; i < wait_cycles; i++) begin
            if (poke && i == 0) begin
                fetch_start = 1'b1;
                pc          = 32'hDEAD_0000;
            end
            @(posedge clk); #1;
            fetch_start = 1'b0;
            chk("wait_req",  {31'd0, im_req},    32'd1);
            chk("wait_addr", im_addr,            a);
            chk("wait_dv",   {31'd0, dec_valid}, 32'd0);
        end
        im_ack   = 1'b1;
        im_rdata = d;
        @(posedge clk); #1;
        im_ack   = 1'b0;
        im_rdata = 32'd0;
        chk("ack_dv",   {31'd0, dec_valid}, 32'd1);
        chk("ack_busy", {31'd0, busy},      32'd0);
        chk("ack_req",  {31'd0, im_req},    32'd0);
        chk("ack_ir",   ir,                 d);
    endtask

    logic [31:0] tbl_word [8];
    logic [31:0] tbl_exp  [8];

    initial begin
        tbl_word = '{32'h0000_0000, 32'h0022_1822, 32'h1022_0003, 32'h03E0_0008,
                     32'h3C01_1234, 32'h0002_1883, 32'h2C22_0001, 32'h3422_00FF};
        tbl_exp  = '{32'h0000_0400, 32'h0000_0004, 32'h0100_0000, 32'h0001_0000,
                     32'h1000_0000, 32'h0000_1000, 32'h0800_0000, 32'h0010_0000};

        rst_n = 1'b0; pc = 32'd0; fetch_start = 1'b0; im_ack = 1'b0; im_rdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req",   {31'd0, im_req},    32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_addr",  im_addr,            32'd0);
        chk("rst_ir",    ir,                 32'd0);
        chk("rst_inst",  instruct,           32'd0);
        chk("rst_dv",    {31'd0, dec_valid}, 32'd0);
        chk("rst_berr",  {31'd0, bus_err},   32'd0);
        chk("rst_cnt",   {28'd0, illegal_cnt}, 32'd0);
        rst_n = 1'b1;

        // add, ack in first REQ cycle
        do_fetch(32'h0040_0000, 32'h0022_1820, 0, 1'b0);
        chk("add_inst", instruct, 32'h0000_0001);
        @(posedge clk); #1;
        chk("add_dv_pulse", {31'd0, dec_valid}, 32'd0);
        chk("add_hold", instruct, 32'h0000_0001);

        // lw, ack delayed 5 cycles
        do_fetch(32'h0040_0004, 32'h8C22_0004, 5, 1'b0);
        chk("lw_inst", instruct, 32'h0040_0000);

        // jal with fetch_start poked during REQ
        do_fetch(32'h0040_0008, 32'h0C00_0010, 2, 1'b1);
        chk("jal_inst", instruct, 32'h4000_0000);
        @(posedge clk); #1;
        chk("jal_no_refetch", {31'd0, im_req}, 32'd0);
        chk("jal_addr_kept",  im_addr, 32'h0040_0008);

        // assorted decodes
        for (int i = 0; i < 8; i++) begin
            do_fetch(32'h0040_0010 + 32'(i * 4), tbl_word[i], i % 3, 1'b0);
            chk($sformatf("dec_%0d", i), instruct, tbl_exp[i]);
        end
        chk("legal_cnt", {28'd0, illegal_cnt}, 32'd0);

        // illegal opcode twice
        do_fetch(32'h0040_0100, 32'hFC00_0000, 0, 1'b0);
        chk("ill1_inst", instruct, 32'h8000_0000);
        do_fetch(32'h0040_0104, 32'hFC00_0000, 1, 1'b0);
        chk("ill2_inst", instruct, 32'h8000_0000);
        chk("ill2_cnt", {28'd0, illegal_cnt}, 32'd2);

        // drive the 4-bit counter to saturation
        for (int i = 0; i < 13; i++) begin
            do_fetch(32'h0040_0200, 32'hFC00_0000, 0, 1'b0);
        end
        chk("cnt_full", {28'd0, illegal_cnt}, 32'd15);
        do_fetch(32'h0040_0204, 32'h0000_0001, 0, 1'b0);
        chk("cnt_sat", {28'd0, illegal_cnt}, 32'd15);
        chk("rfunct_ill", instruct, 32'h8000_0000);

        // ack while idle is ignored
        @(posedge clk); #1;
        im_ack = 1'b1; im_rdata = 32'h0022_1820;
        @(posedge clk); #1;
        im_ack = 1'b0; im_rdata = 32'd0;
        chk("idle_ack_dv",   {31'd0, dec_valid}, 32'd0);
        chk("idle_ack_ir",   ir, 32'h0000_0001);
        chk("idle_ack_inst", instruct, 32'h8000_0000);

        // timeout: 8 REQ cycles with no ack
        @(posedge clk); #1;
        pc = 32'h0040_0300; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        chk("to_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("to_wait_req",  {31'd0, im_req},  32'd1);
            chk("to_wait_berr", {31'd0, bus_err}, 32'd0);
        end
        @(posedge clk); #1;
        chk("to_berr", {31'd0, bus_err},   32'd1);
        chk("to_req",  {31'd0, im_req},    32'd0);
        chk("to_busy_off", {31'd0, busy},  32'd0);
        chk("to_inst", instruct,           32'd0);
        chk("to_dv",   {31'd0, dec_valid}, 32'd0);
        chk("to_ir",   ir,                 32'h0000_0001);
        @(posedge clk); #1;
        chk("to_sticky", {31'd0, bus_err}, 32'd1);

        // ack on the final allowed cycle wins over timeout
        do_fetch(32'h0040_0400, 32'h2C22_0001, 7, 1'b0);
        chk("last_inst", instruct, 32'h0800_0000);
        chk("last_berr", {31'd0, bus_err}, 32'd0);

        // async reset mid-REQ, then a late ack
        @(posedge clk); #1;
        pc = 32'h0040_0500; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  {31'd0, im_req}, 32'd0);
        chk("arst_busy", {31'd0, busy},   32'd0);
        chk("arst_inst", instruct,        32'd0);
        chk("arst_ir",   ir,              32'd0);
        chk("arst_cnt",  {28'd0, illegal_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        im_ack = 1'b1; im_rdata = 32'h0022_1820;
        @(posedge clk); #1;
        im_ack = 1'b0;
        chk("late_ack_dv", {31'd0, dec_valid}, 32'd0);
        chk("late_ack_ir", ir, 32'd0);
        chk("late_ack_req", {31'd0, im_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
